adc_calib_pipe: RTL and testbench
=================================

Name: adc_calib_pipe

Overview:
- Parametrised per-channel runtime calibration stage placed after the ADC controller's channel outputs, in the i_sys_clock domain.
- Applies an offset and gain to NB_CHANNELS signed samples, then saturates them.
- Both coefficients are writable at runtime and committed atomically. Static coefficient tie-offs are no longer used.
- Optionally averages 2^k samples, which decimates the output rate.

Parameters:
- NB_CHANNELS, 2, number of sample lanes
- ADC_CHDATA_SIZE, 16, signed sample width in and out
- ADC_CALIB_SIZE, 18, coefficient width (signed)
- DECIM_MAX_LOG2, 4, maximum decimation exponent k

Ports:
- i_sys_clock  in  1  sole clock
- i_reset  in  1  synchronous reset, active-low
- i_valid  in  1  input sample strobe, all channels together
- i_data  in  NB_CHANNELS*ADC_CHDATA_SIZE  channel c occupies bits [c*ADC_CHDATA_SIZE +: ADC_CHDATA_SIZE]
- i_coef_we  in  1  shadow coefficient write strobe
- i_coef_sel  in  $clog2(NB_CHANNELS) (min 1)  target channel for the write
- i_coef_kind  in  1  0 = add coefficient, 1 = mult coefficient
- i_coef_data  in  ADC_CALIB_SIZE  coefficient value
- i_coef_commit  in  1  copy all shadow coefficients to active
- i_decim_log2  in  $clog2(DECIM_MAX_LOG2+1)  decimation exponent k
- i_sat_clear  in  1  clear the sticky saturation flags
- o_valid  out  1  output strobe
- o_data  out  NB_CHANNELS*ADC_CHDATA_SIZE  calibrated samples
- o_sat  out  NB_CHANNELS  sticky per-channel saturation flags

Behaviour:
- Reset (i_reset low at a clock edge) sets:
  - o_valid=0, o_data=0, o_sat=0, and all pipeline valids to 0.
  - The decimation accumulator and counter to 0.
  - Shadow and active mult coefficients to 0x10000 (1.0); add coefficients to 0.
- Reset mid-operation discards in-flight and partially accumulated samples. Nothing is emitted for them.
- Coefficient formats:
  - mult: signed Q2.16, where 0x10000 = 1.0.
  - add: signed integer in output LSBs.
- Writes and commit:
  - i_coef_we writes the shadow register selected by i_coef_sel and i_coef_kind.
  - An out-of-range i_coef_sel is ignored.
  - i_coef_commit copies every shadow coefficient to active in one cycle.
  - If i_coef_we and i_coef_commit are high in the same cycle, the commit copies the pre-write shadow; the write lands in shadow only.
- Per-lane pipeline, no stalls (i_valid may be high every cycle):
  - S1: register the sample together with a snapshot of the active coefficients. A commit in the same cycle as i_valid means that sample uses the OLD coefficients.
  - S2: product = sample*mult, ADC_CHDATA_SIZE+ADC_CALIB_SIZE bits, signed.
  - S3: add 2^15, arithmetic shift right by 16 (round half up), then add the sign-extended add coefficient. Keep 2 guard bits so there is no wrap.
  - S4: saturate to [-2^(ADC_CHDATA_SIZE-1), 2^(ADC_CHDATA_SIZE-1)-1].
- Latency is 4 cycles from i_valid to o_valid (decimator absent, or k=0).
- o_valid is a 1-cycle pulse per result. o_data holds its value between pulses.
- o_sat[c] sets when lane c clamps in S4 and stays set until i_sat_clear. If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: ADC_CALIB_DECIM_EN.
- When defined, an accumulate stage follows S4:
  - Per-lane accumulator, ADC_CHDATA_SIZE+DECIM_MAX_LOG2 bits.
  - k is sampled when the counter is 0. Changes to k mid-block are ignored until the block completes. k > DECIM_MAX_LOG2 clamps to DECIM_MAX_LOG2.
  - After 2^k saturated samples, output sum >>> k (floor), pulse o_valid, and clear the accumulator.
  - Latency is 5 cycles from the last input sample of a block; k=0 gives 1:1 output at latency 5.
- When undefined, i_decim_log2 is ignored and latency is 4.

Decomposition:
- Package adc_calib_pkg holds:
  - FRAC_BITS=16, MULT_UNITY=18'h10000, ROUND_CONST=1<<15.
  - Coefficient-kind encodings COEF_ADD=0 and COEF_MULT=1.
  - Saturation min/max constants derived from ADC_CHDATA_SIZE.
- Sub-module adc_calib_lane (S2–S4, plus the accumulator under the macro) is generated NB_CHANNELS times.
- The top level owns the shadow/active registers, the S1 snapshot, valid tracking and o_sat.

Test Plan:
- After reset, input ch0=1000, ch1=-500 with i_valid → 4 cycles later o_valid=1, o_data ch0=1000, ch1=-500, o_sat=0.
- Write ch0 mult=0x08000 and add=10, commit, input ch0=1001 → o_data ch0=511 (500.5 rounds to 501, +10); ch1 unchanged.
- Write ch1 mult=0x1FFFF, commit, input ch1=30000 → ch1=32767 and o_sat[1]=1, which persists. Pulse i_sat_clear → 0. Input -30000 → -32768.
- Assert commit in the same cycle as i_valid for sample A, then sample B next cycle → A uses the old coefficients, B the new.
- With the macro and k=2, input ch0 = 4, 8, 12, 17 on consecutive cycles → a single o_valid with ch0=10 (41>>>2), 5 cycles after the 4th sample.
- With the macro and k=2, feed 2 samples then pulse i_reset low for one cycle → no o_valid. The next 4 samples of value 7 → ch0=7.

Source files
------------

// File: rtl/adc_calib_pkg.sv
`default_nettype none
//==============================================================================
// Package     : adc_calib_pkg
// Description : Shared constants and helpers for the ADC calibration pipeline.
//               - FRAC_BITS / MULT_UNITY : Q2.16 gain format (0x10000 = 1.0)
//               - ROUND_CONST            : half-LSB added before the shift
//               - COEF_ADD / COEF_MULT   : coefficient-kind select encodings
//               - sat_max() / sat_min()  : signed clamp bounds for a sample width
// Revision    : 1.0 - initial release
//==============================================================================
package adc_calib_pkg;

    localparam int          FRAC_BITS   = 16;
    localparam logic [17:0] MULT_UNITY  = 18'h10000;
    localparam int          ROUND_CONST = 1 << 15;

    localparam logic COEF_ADD  = 1'b0;
    localparam logic COEF_MULT = 1'b1;

    // Clamp bounds derived from the sample width (ADC_CHDATA_SIZE at the call site).
    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_calib_lane.sv
`default_nettype none
//==============================================================================
// Module      : adc_calib_lane
// Description : One calibration lane, stages S2..S4 (multiply, round + offset,
//               saturate), plus an optional 2^k block averager after S4.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_valid           - S1 sample valid
//               i_sample          - S1 signed sample
//               i_mult / i_add    - S1 coefficient snapshot (Q2.16 gain, LSB offset)
//               i_decim_log2      - decimation exponent (ADC_CALIB_DECIM_EN only)
//               o_valid / o_data  - calibrated result strobe and value
//               o_clamp           - S3 result is being clamped at this edge
// Config      : ADC_CALIB_DECIM_EN enables the averaging stage.
// Revision    : 1.0 - initial release
//==============================================================================
module adc_calib_lane
    import adc_calib_pkg::*;
#(
    parameter int ADC_CHDATA_SIZE = 16,
    parameter int ADC_CALIB_SIZE  = 18
`ifdef ADC_CALIB_DECIM_EN
    ,
    parameter int DECIM_MAX_LOG2  = 4
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_valid,
    input  logic signed [ADC_CHDATA_SIZE-1:0] i_sample,
    input  logic signed [ADC_CALIB_SIZE-1:0]  i_mult,
    input  logic signed [ADC_CALIB_SIZE-1:0]  i_add,
`ifdef ADC_CALIB_DECIM_EN
    input  logic [$clog2(DECIM_MAX_LOG2+1)-1:0] i_decim_log2,
`endif
    output logic                              o_valid,
    output logic [ADC_CHDATA_SIZE-1:0]        o_data,
    output logic                              o_clamp
);

    localparam int PROD_W = ADC_CHDATA_SIZE + ADC_CALIB_SIZE;
    // Rounded product plus offset, with two guard bits so the add never wraps.
    localparam int SUM_W  = PROD_W - FRAC_BITS + 2;

    localparam logic signed [SUM_W-1:0] c_sat_max = SUM_W'(sat_max(ADC_CHDATA_SIZE));
    localparam logic signed [SUM_W-1:0] c_sat_min = SUM_W'(sat_min(ADC_CHDATA_SIZE));

    // ---------------- S2: product ----------------
    logic                             r_s2_valid;
    logic signed [PROD_W-1:0]         r_s2_prod;
    logic signed [ADC_CALIB_SIZE-1:0] r_s2_add;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_add   <= '0;
        end else begin
            r_s2_valid <= i_valid;
            r_s2_prod  <= PROD_W'(i_sample) * PROD_W'(i_mult);
            r_s2_add   <= i_add;
        end
    end

    // ---------------- S3: round half up, then offset ----------------
    logic signed [PROD_W-1:0] w_rounded;
    logic signed [SUM_W-1:0]  w_sum;
    logic                     r_s3_valid;
    logic signed [SUM_W-1:0]  r_s3_sum;

    assign w_rounded = (r_s2_prod + PROD_W'(ROUND_CONST)) >>> FRAC_BITS;
    assign w_sum     = SUM_W'(w_rounded) + SUM_W'(r_s2_add);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_sum   <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_sum   <= w_sum;
        end
    end

    // ---------------- S4: saturate ----------------
    logic                              w_hi;
    logic                              w_lo;
    logic signed [ADC_CHDATA_SIZE-1:0] w_sat_data;
    logic                              r_s4_valid;
    logic signed [ADC_CHDATA_SIZE-1:0] r_s4_data;

    assign w_hi       = (r_s3_sum > c_sat_max);
    assign w_lo       = (r_s3_sum < c_sat_min);
    assign w_sat_data = w_hi ? c_sat_max[ADC_CHDATA_SIZE-1:0] :
                        w_lo ? c_sat_min[ADC_CHDATA_SIZE-1:0] :
                               r_s3_sum[ADC_CHDATA_SIZE-1:0];
    assign o_clamp    = r_s3_valid & (w_hi | w_lo);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s4_valid <= 1'b0;
            r_s4_data  <= '0;
        end else begin
            r_s4_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_s4_data <= w_sat_data;
            end
        end
    end

`ifdef ADC_CALIB_DECIM_EN
    // ---------------- Block averager ----------------
    localparam int K_W   = $clog2(DECIM_MAX_LOG2 + 1);
    localparam int ACC_W = ADC_CHDATA_SIZE + DECIM_MAX_LOG2;
    localparam int CNT_W = (DECIM_MAX_LOG2 > 0) ? DECIM_MAX_LOG2 : 1;

    logic [K_W-1:0]                    r_k;
    logic [K_W-1:0]                    w_k_in;
    logic [K_W-1:0]                    w_k;
    logic [CNT_W-1:0]                  r_cnt;
    logic signed [ACC_W-1:0]           r_acc;
    logic signed [ACC_W-1:0]           w_acc_next;
    logic signed [ADC_CHDATA_SIZE-1:0] w_avg;
    logic                              w_block_done;
    logic                              r_out_valid;
    logic [ADC_CHDATA_SIZE-1:0]        r_out_data;

    always_comb begin
        w_k_in       = (int'(i_decim_log2) > DECIM_MAX_LOG2) ? K_W'(DECIM_MAX_LOG2) : i_decim_log2;
        // The exponent is latched on the first sample of a block and held to its end.
        w_k          = (r_cnt == '0) ? w_k_in : r_k;
        w_acc_next   = r_acc + ACC_W'(r_s4_data);
        w_block_done = (int'(r_cnt) == ((1 << w_k) - 1));
        w_avg        = ADC_CHDATA_SIZE'(w_acc_next >>> w_k);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_s4_valid) begin
                r_k <= w_k;
                if (w_block_done) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_avg;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
`else
    assign o_valid = r_s4_valid;
    assign o_data  = r_s4_data;
`endif

endmodule
`default_nettype wire

// File: rtl/adc_calib_pipe.sv
`default_nettype none
//==============================================================================
// Module      : adc_calib_pipe
// Description : Runtime per-channel offset/gain calibration with saturation.
//               Owns the shadow/active coefficient banks, the S1 sample +
//               coefficient snapshot and the sticky saturation flags; the
//               arithmetic lives in one adc_calib_lane per channel.
// Ports       : i_sys_clock    - clock
//               i_reset        - synchronous reset, active-low
//               i_valid/i_data - input strobe and packed channel samples
//               i_coef_we/sel/kind/data - shadow coefficient write
//               i_coef_commit  - copy every shadow coefficient to active
//               i_decim_log2   - averaging exponent k
//               i_sat_clear    - clear sticky saturation flags
//               o_valid/o_data - result strobe and packed calibrated samples
//               o_sat          - sticky per-channel saturation flags
// Config      : ADC_CALIB_DECIM_EN adds a 2^k averaging stage (latency 5);
//               without it i_decim_log2 is ignored (latency 4).
// Revision    : 1.0 - initial release
//==============================================================================
module adc_calib_pipe
    import adc_calib_pkg::*;
#(
    parameter int NB_CHANNELS     = 2,
    parameter int ADC_CHDATA_SIZE = 16,
    parameter int ADC_CALIB_SIZE  = 18,
    parameter int DECIM_MAX_LOG2  = 4
) (
    input  logic                                    i_sys_clock,
    input  logic                                    i_reset,
    input  logic                                    i_valid,
    input  logic [NB_CHANNELS*ADC_CHDATA_SIZE-1:0]  i_data,
    input  logic                                    i_coef_we,
    input  logic [((NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1)-1:0] i_coef_sel,
    input  logic                                    i_coef_kind,
    input  logic [ADC_CALIB_SIZE-1:0]               i_coef_data,
    input  logic                                    i_coef_commit,
    input  logic [$clog2(DECIM_MAX_LOG2+1)-1:0]     i_decim_log2,
    input  logic                                    i_sat_clear,
    output logic                                    o_valid,
    output logic [NB_CHANNELS*ADC_CHDATA_SIZE-1:0]  o_data,
    output logic [NB_CHANNELS-1:0]                  o_sat
);

    logic signed [ADC_CALIB_SIZE-1:0]  r_sh_mult  [NB_CHANNELS];
    logic signed [ADC_CALIB_SIZE-1:0]  r_sh_add   [NB_CHANNELS];
    logic signed [ADC_CALIB_SIZE-1:0]  r_act_mult [NB_CHANNELS];
    logic signed [ADC_CALIB_SIZE-1:0]  r_act_add  [NB_CHANNELS];

    logic                              r_s1_valid;
    logic signed [ADC_CHDATA_SIZE-1:0] r_s1_sample [NB_CHANNELS];
    logic signed [ADC_CALIB_SIZE-1:0]  r_s1_mult   [NB_CHANNELS];
    logic signed [ADC_CALIB_SIZE-1:0]  r_s1_add    [NB_CHANNELS];

    logic [NB_CHANNELS-1:0]            w_lane_valid;
    logic [NB_CHANNELS-1:0]            w_lane_clamp;
    logic [ADC_CHDATA_SIZE-1:0]        w_lane_data [NB_CHANNELS];
    logic [NB_CHANNELS-1:0]            r_sat;

    // Commit reads the shadow bank before this edge's write lands, so a
    // simultaneous write only reaches the shadow copy.
    always_ff @(posedge i_sys_clock) begin
        if (!i_reset) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                r_sh_mult[c]  <= ADC_CALIB_SIZE'(MULT_UNITY);
                r_sh_add[c]   <= '0;
                r_act_mult[c] <= ADC_CALIB_SIZE'(MULT_UNITY);
                r_act_add[c]  <= '0;
            end
        end else begin
            if (i_coef_commit) begin
                for (int c = 0; c < NB_CHANNELS; c++) begin
                    r_act_mult[c] <= r_sh_mult[c];
                    r_act_add[c]  <= r_sh_add[c];
                end
            end
            if (i_coef_we && (int'(i_coef_sel) < NB_CHANNELS)) begin
                case (i_coef_kind)
                    COEF_MULT: r_sh_mult[i_coef_sel] <= i_coef_data;
                    COEF_ADD:  r_sh_add[i_coef_sel]  <= i_coef_data;
                endcase
            end
        end
    end

    // S1: the snapshot takes the active bank as it stood before any commit
    // on this same edge.
    always_ff @(posedge i_sys_clock) begin
        if (!i_reset) begin
            r_s1_valid <= 1'b0;
            for (int c = 0; c < NB_CHANNELS; c++) begin
                r_s1_sample[c] <= '0;
                r_s1_mult[c]   <= '0;
                r_s1_add[c]    <= '0;
            end
        end else begin
            r_s1_valid <= i_valid;
            for (int c = 0; c < NB_CHANNELS; c++) begin
                r_s1_sample[c] <= i_data[c*ADC_CHDATA_SIZE +: ADC_CHDATA_SIZE];
                r_s1_mult[c]   <= r_act_mult[c];
                r_s1_add[c]    <= r_act_add[c];
            end
        end
    end

    generate
        for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_lane
`ifdef ADC_CALIB_DECIM_EN
            adc_calib_lane #(
                .ADC_CHDATA_SIZE (ADC_CHDATA_SIZE),
                .ADC_CALIB_SIZE  (ADC_CALIB_SIZE),
                .DECIM_MAX_LOG2  (DECIM_MAX_LOG2)
            ) u_lane (
                .clk          (i_sys_clock),
                .rst_n        (i_reset),
                .i_valid      (r_s1_valid),
                .i_sample     (r_s1_sample[c]),
                .i_mult       (r_s1_mult[c]),
                .i_add        (r_s1_add[c]),
                .i_decim_log2 (i_decim_log2),
                .o_valid      (w_lane_valid[c]),
                .o_data       (w_lane_data[c]),
                .o_clamp      (w_lane_clamp[c])
            );
`else
            adc_calib_lane #(
                .ADC_CHDATA_SIZE (ADC_CHDATA_SIZE),
                .ADC_CALIB_SIZE  (ADC_CALIB_SIZE)
            ) u_lane (
                .clk      (i_sys_clock),
                .rst_n    (i_reset),
                .i_valid  (r_s1_valid),
                .i_sample (r_s1_sample[c]),
                .i_mult   (r_s1_mult[c]),
                .i_add    (r_s1_add[c]),
                .o_valid  (w_lane_valid[c]),
                .o_data   (w_lane_data[c]),
                .o_clamp  (w_lane_clamp[c])
            );
`endif
            assign o_data[c*ADC_CHDATA_SIZE +: ADC_CHDATA_SIZE] = w_lane_data[c];
        end
    endgenerate

`ifdef ADC_CALIB_DECIM_EN
`else
    logic w_unused_decim;
    assign w_unused_decim = ^i_decim_log2;
`endif

    // All lanes share one valid chain, so their strobes are identical.
    assign o_valid = &w_lane_valid;

    // Sticky flags: a clamp on the same edge as a clear still sets the flag.
    always_ff @(posedge i_sys_clock) begin
        if (!i_reset) begin
            r_sat <= '0;
        end else begin
            r_sat <= (i_sat_clear ? '0 : r_sat) | w_lane_clamp;
        end
    end

    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_adc_calib_pipe.sv
`default_nettype none
//==============================================================================
// Module      : tb_adc_calib_pipe
// Description : Self-checking bench for adc_calib_pipe: directed scenarios and
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_adc_calib_pipe;

    localparam int NB   = 2;
    localparam int DW   = 16;
    localparam int CW   = 18;
    localparam int DMAX = 4;
`ifdef ADC_CALIB_DECIM_EN
    localparam bit DECIM = 1'b1;
`else
    localparam bit DECIM = 1'b0;
`endif

    logic               clk;
    logic               i_reset;
    logic               i_valid;
    logic [NB*DW-1:0]   i_data;
    logic               i_coef_we;
    logic [0:0]         i_coef_sel;
    logic               i_coef_kind;
    logic [CW-1:0]      i_coef_data;
    logic               i_coef_commit;
    logic [2:0]         i_decim_log2;
    logic               i_sat_clear;
    logic               o_valid;
    logic [NB*DW-1:0]   o_data;
    logic [NB-1:0]      o_sat;

    adc_calib_pipe dut (
        .i_sys_clock   (clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_coef_we     (i_coef_we),
        .i_coef_sel    (i_coef_sel),
        .i_coef_kind   (i_coef_kind),
        .i_coef_data   (i_coef_data),
        .i_coef_commit (i_coef_commit),
        .i_decim_log2  (i_decim_log2),
        .i_sat_clear   (i_sat_clear),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_sat         (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct packed { int due; logic [NB*DW-1:0] data; } out_t;
    typedef struct packed { int due; logic [NB-1:0] mask; } sat_t;

    out_t          out_q[$];
    sat_t          sat_q[$];
    int            sh_mult[NB], sh_add[NB], act_mult[NB], act_add[NB];
    logic [NB*DW-1:0] m_data;
    logic [NB-1:0] m_sat;
    int            blk_cnt, blk_k;
    longint        blk_sum[NB];
    int            cyc;
    int            n_checks, n_fail;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Calibrated value of one sample: round(sample*gain) + offset, clamped.
    function automatic int calib(input int s, input int m, input int a, output bit cl);
        longint r;
        r  = ((longint'(s) * longint'(m)) + 64'sd32768) >>> 16;
        r  = r + a;
        cl = 1'b0;
        if (r > 32767) begin r = 32767; cl = 1'b1; end
        else if (r < -32768) begin r = -32768; cl = 1'b1; end
        return int'(r);
    endfunction

    // One clock: advance the model with the applied inputs, then compare.
    task automatic tick();
        int   v;
        bit   cl;
        out_t o;
        sat_t s;
        logic exp_valid;
        @(posedge clk);
        cyc++;
        exp_valid = 1'b0;
        if (!i_reset) begin
            out_q.delete();
            sat_q.delete();
            m_sat   = '0;
            m_data  = '0;
            blk_cnt = 0;
            for (int c = 0; c < NB; c++) begin
                sh_mult[c] = 65536; act_mult[c] = 65536;
                sh_add[c]  = 0;     act_add[c]  = 0;
                blk_sum[c] = 0;
            end
        end else begin
            if (i_valid) begin
                s.due  = cyc + 3;
                s.mask = '0;
                o.data = '0;
                for (int c = 0; c < NB; c++) begin
                    v = calib(int'($signed(i_data[c*DW +: DW])), act_mult[c], act_add[c], cl);
                    s.mask[c] = cl;
                    o.data[c*DW +: DW] = DW'(v);
                    blk_sum[c] += v;
                end
                sat_q.push_back(s);
                if (DECIM) begin
                    if (blk_cnt == 0) blk_k = (int'(i_decim_log2) > DMAX) ? DMAX : int'(i_decim_log2);
                    blk_cnt++;
                    if (blk_cnt == (1 << blk_k)) begin
                        for (int c = 0; c < NB; c++) begin
                            o.data[c*DW +: DW] = DW'(blk_sum[c] >>> blk_k);
                            blk_sum[c] = 0;
                        end
                        o.due   = cyc + 4;
                        blk_cnt = 0;
                        out_q.push_back(o);
                    end
                end else begin
                    for (int c = 0; c < NB; c++) blk_sum[c] = 0;
                    o.due = cyc + 3;
                    out_q.push_back(o);
                end
            end
            if (i_coef_commit) begin
                for (int c = 0; c < NB; c++) begin
                    act_mult[c] = sh_mult[c];
                    act_add[c]  = sh_add[c];
                end
            end
            if (i_coef_we) begin
                if (i_coef_kind) sh_mult[i_coef_sel] = int'($signed(i_coef_data));
                else             sh_add[i_coef_sel]  = int'($signed(i_coef_data));
            end
            if (i_sat_clear) m_sat = '0;
            while (sat_q.size() > 0 && sat_q[0].due == cyc) begin
                m_sat = m_sat | sat_q[0].mask;
                void'(sat_q.pop_front());
            end
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                exp_valid = 1'b1;
                m_data    = out_q[0].data;
                void'(out_q.pop_front());
            end
        end
        #1;
        check_val("o_valid", o_valid, exp_valid);
        check_val("o_data", o_data, m_data);
        check_val("o_sat", o_sat, m_sat);
        i_valid       = 1'b0;
        i_coef_we     = 1'b0;
        i_coef_commit = 1'b0;
        i_sat_clear   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sample(input int d0, input int d1);
        i_valid = 1'b1;
        i_data  = {DW'(d1), DW'(d0)};
        tick();
    endtask

    task automatic wr(input int sel, input int kind, input int val);
        i_coef_we   = 1'b1;
        i_coef_sel  = 1'(sel);
        i_coef_kind = 1'(kind);
        i_coef_data = CW'(val);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        blk_cnt = 0; blk_k = 0; m_data = '0; m_sat = '0;
        i_reset = 1'b0; i_valid = 1'b0; i_data = '0;
        i_coef_we = 1'b0; i_coef_sel = '0; i_coef_kind = 1'b0; i_coef_data = '0;
        i_coef_commit = 1'b0; i_decim_log2 = '0; i_sat_clear = 1'b0;
        for (int c = 0; c < NB; c++) begin
            sh_mult[c] = 65536; act_mult[c] = 65536; sh_add[c] = 0; act_add[c] = 0; blk_sum[c] = 0;
        end

        // Reset state
        idle(2);
        check_val("rst_valid", o_valid, 0);
        check_val("rst_data", o_data, 0);
        check_val("rst_sat", o_sat, 0);
        i_reset = 1'b1;
        idle(2);

        // Unity pass-through, 4-cycle latency
        sample(1000, -500);
        idle(3);
        check_val("t1_valid", o_valid, 1);
        check_val("t1_ch0", $signed(o_data[15:0]), 1000);
        check_val("t1_ch1", $signed(o_data[31:16]), -500);
        check_val("t1_sat", o_sat, 0);

        // Gain 0.5 and offset 10 on ch0
        wr(0, 1, 'h08000);
        wr(0, 0, 10);
        i_coef_commit = 1'b1; tick();
        sample(1001, 7);
        idle(3);
        check_val("t2_ch0", $signed(o_data[15:0]), 511);
        check_val("t2_ch1", $signed(o_data[31:16]), 7);

        // Saturation and sticky flag on ch1
        wr(1, 1, 'h1FFFF);
        i_coef_commit = 1'b1; tick();
        sample(0, 30000);
        idle(3);
        check_val("t3_ch1_hi", $signed(o_data[31:16]), 32767);
        check_val("t3_sat_set", o_sat, 2);
        idle(3);
        check_val("t3_sat_hold", o_sat, 2);
        i_sat_clear = 1'b1; tick();
        check_val("t3_sat_clr", o_sat, 0);
        sample(0, -30000);
        idle(3);
        check_val("t3_ch1_lo", $signed(o_data[31:16]), -32768);
        check_val("t3_sat_lo", o_sat, 2);

        // Commit coinciding with sample A: A keeps old gain, B sees the new one
        wr(0, 1, 'h0C000);
        i_coef_commit = 1'b1;
        sample(100, 0);
        sample(100, 0);
        idle(2);
        check_val("t4_a_old", $signed(o_data[15:0]), 60);
        idle(1);
        check_val("t4_b_new", $signed(o_data[15:0]), 85);
        idle(4);

`ifdef ADC_CALIB_DECIM_EN
        // Average of four samples with k=2
        i_reset = 1'b0; tick(); i_reset = 1'b1;
        i_decim_log2 = 3'd2;
        idle(2);
        sample(4, 0); sample(8, 0); sample(12, 0); sample(17, 0);
        idle(4);
        check_val("d1_valid", o_valid, 1);
        check_val("d1_avg", $signed(o_data[15:0]), 10);
        // Partial block discarded by reset
        sample(1, 0); sample(1, 0);
        i_reset = 1'b0; tick(); i_reset = 1'b1;
        for (int i = 0; i < 4; i++) sample(7, 0);
        idle(4);
        check_val("d2_valid", o_valid, 1);
        check_val("d2_avg", $signed(o_data[15:0]), 7);
        idle(6);
`endif

        // Randomized traffic
        i_decim_log2 = 3'($urandom_range(0, 7));
        for (int i = 0; i < 600; i++) begin
            i_reset = ($urandom_range(0, 199) != 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                i_coef_we   = 1'b1;
                i_coef_sel  = 1'($urandom_range(0, NB - 1));
                i_coef_kind = 1'($urandom_range(0, 1));
                if (i_coef_kind)
                    i_coef_data = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(32768, 98304));
                else
                    i_coef_data = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'(int'($urandom_range(0, 2000)) - 1000);
            end
            i_coef_commit = ($urandom_range(0, 9) == 0);
            i_sat_clear   = ($urandom_range(0, 15) == 0);
            tick();
        end
        i_reset = 1'b1;
        idle(40);
        check_val("drain_empty", out_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
